four_bit_comparator: RTL and testbench

- Magnitude comparator for two unsigned 4-bit operands, A and B, supplied as individual scalar bits.
- Produces one-hot greater / less / equal flags, registered on the system clock with 1-cycle latency.
- Used as a leaf compare cell in datapath control; cascadable via the optional feature.

---
 rtl/comparator_pkg.sv | 51 +++++
 rtl/bit_compare_cell.sv | 35 +++
 rtl/four_bit_comparator.sv | 127 ++++++++++++
 tb/tb_four_bit_comparator.sv | 128 ++++++++++++
 4 files changed

// File: rtl/comparator_pkg.sv
// -----------------------------------------------------------------------------
// comparator_pkg
//
// Shared definitions for the four_bit_comparator slice.
//   CMP_WIDTH     operand width, fixed by the scalar bit ports of the top
//   cmp_result_e  internal compare verdict, carried before decode to flags
//   cmp_encode    {gt, lt, eq} flags -> verdict, priority gt > lt > eq
//   cmp_decode    verdict -> {gt, lt, eq} flags
// -----------------------------------------------------------------------------
package comparator_pkg;

    localparam int CMP_WIDTH = 4;

    typedef enum logic [1:0] {
        CMP_NONE = 2'd0,
        CMP_LT   = 2'd1,
        CMP_EQ   = 2'd2,
        CMP_GT   = 2'd3
    } cmp_result_e;

    // Non-one-hot inputs resolve by priority so that a malformed cascade
    // input can never produce more than one asserted flag downstream.
    function automatic cmp_result_e cmp_encode(input logic gt,
                                               input logic lt,
                                               input logic eq);
        cmp_result_e res;
        if (gt) begin
            res = CMP_GT;
        end else if (lt) begin
            res = CMP_LT;
        end else if (eq) begin
            res = CMP_EQ;
        end else begin
            res = CMP_NONE;
        end
        return res;
    endfunction

    // Returns {gt, lt, eq}.
    function automatic logic [2:0] cmp_decode(input cmp_result_e res);
        logic [2:0] flags;
        case (res)
            CMP_GT:  flags = 3'b100;
            CMP_LT:  flags = 3'b010;
            CMP_EQ:  flags = 3'b001;
            default: flags = 3'b000;
        endcase
        return flags;
    endfunction

endpackage

// File: rtl/bit_compare_cell.sv
// -----------------------------------------------------------------------------
// bit_compare_cell
//
// One bit of an MSB-first magnitude compare chain. The upstream triple carries
// the verdict of all more-significant bits; once a difference has been found
// (eq_in = 0) it passes through untouched, otherwise this bit decides.
//
// Ports
//   a_i, b_i                  operand bits at this position
//   gt_in, lt_in, eq_in       verdict from the more-significant bits
//   gt_out, lt_out, eq_out    verdict including this bit
// -----------------------------------------------------------------------------
module bit_compare_cell (
    input  logic a_i,
    input  logic b_i,
    input  logic gt_in,
    input  logic lt_in,
    input  logic eq_in,
    output logic gt_out,
    output logic lt_out,
    output logic eq_out
);

    always_comb begin
        gt_out = gt_in;
        lt_out = lt_in;
        eq_out = 1'b0;
        if (eq_in) begin
            gt_out = a_i & ~b_i;
            lt_out = ~a_i & b_i;
            eq_out = ~(a_i ^ b_i);
        end
    end

endmodule

// File: rtl/four_bit_comparator.sv
// -----------------------------------------------------------------------------
// four_bit_comparator
//
// Registered magnitude comparator for two unsigned 4-bit operands given as
// scalar bits. Four bit_compare_cell instances are chained MSB to LSB; the
// verdict is loaded into the flag register when in_valid is high and held
// otherwise. out_valid marks the cycle after each accepted operand pair.
//
// Ports
//   clk                 system clock, rising edge
//   rst                 asynchronous active-high reset, clears flags/out_valid
//   A3..A0, B3..B0      operand bits (3 = MSB)
//   in_valid            operands valid this cycle
//   A_gt_B, A_lt_B,     registered compare flags, one-hot after the first
//   A_eq_B              valid result, all zero out of reset
//   out_valid           flags hold a fresh result this cycle
//
// Build option
//   FOUR_BIT_COMPARATOR_CASCADE_EN
//       adds casc_gt_in / casc_lt_in / casc_eq_in from a less-significant
//       stage; they decide the result when the local operands are equal.
// -----------------------------------------------------------------------------
module four_bit_comparator
    import comparator_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic A3,
    input  logic A2,
    input  logic A1,
    input  logic A0,
    input  logic B3,
    input  logic B2,
    input  logic B1,
    input  logic B0,
    input  logic in_valid,
`ifdef FOUR_BIT_COMPARATOR_CASCADE_EN
    input  logic casc_gt_in,
    input  logic casc_lt_in,
    input  logic casc_eq_in,
`endif
    output logic A_gt_B,
    output logic A_lt_B,
    output logic A_eq_B,
    output logic out_valid
);

    logic [CMP_WIDTH-1:0] a_vec;
    logic [CMP_WIDTH-1:0] b_vec;

    assign a_vec = {A3, A2, A1, A0};
    assign b_vec = {B3, B2, B1, B0};

    // Index CMP_WIDTH is the chain head ("equal so far"); index 0 is the
    // verdict after the LSB.
    logic [CMP_WIDTH:0] gt_chain;
    logic [CMP_WIDTH:0] lt_chain;
    logic [CMP_WIDTH:0] eq_chain;

    assign gt_chain[CMP_WIDTH] = 1'b0;
    assign lt_chain[CMP_WIDTH] = 1'b0;
    assign eq_chain[CMP_WIDTH] = 1'b1;

    for (genvar i = CMP_WIDTH - 1; i >= 0; i--) begin : g_cell
        bit_compare_cell u_cell (
            .a_i    (a_vec[i]),
            .b_i    (b_vec[i]),
            .gt_in  (gt_chain[i+1]),
            .lt_in  (lt_chain[i+1]),
            .eq_in  (eq_chain[i+1]),
            .gt_out (gt_chain[i]),
            .lt_out (lt_chain[i]),
            .eq_out (eq_chain[i])
        );
    end

    cmp_result_e local_result;
    cmp_result_e final_result;

    assign local_result = cmp_encode(gt_chain[0], lt_chain[0], eq_chain[0]);

`ifdef FOUR_BIT_COMPARATOR_CASCADE_EN
    cmp_result_e casc_result;

    assign casc_result = cmp_encode(casc_gt_in, casc_lt_in, casc_eq_in);

    // Equal local operands defer to the less-significant stage. An all-zero
    // cascade input carries no information, so it reads as "equal".
    always_comb begin
        final_result = local_result;
        if (local_result == CMP_EQ) begin
            final_result = (casc_result == CMP_NONE) ? CMP_EQ : casc_result;
        end
    end
`else
    assign final_result = local_result;
`endif

    logic [2:0] flags_d;
    logic [2:0] flags_q;
    logic       out_valid_d;
    logic       out_valid_q;

    always_comb begin
        flags_d     = flags_q;
        out_valid_d = in_valid;
        if (in_valid) begin
            flags_d = cmp_decode(final_result);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flags_q     <= 3'b000;
            out_valid_q <= 1'b0;
        end else begin
            flags_q     <= flags_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign A_gt_B    = flags_q[2];
    assign A_lt_B    = flags_q[1];
    assign A_eq_B    = flags_q[0];
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_four_bit_comparator.sv
// Directed bench for four_bit_comparator. Observed outputs are packed as
// {out_valid, A_gt_B, A_lt_B, A_eq_B} and sampled 1 ns after the rising edge.
module tb_four_bit_comparator;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic A3 = 1'b0, A2 = 1'b0, A1 = 1'b0, A0 = 1'b0;
    logic B3 = 1'b0, B2 = 1'b0, B1 = 1'b0, B0 = 1'b0;
    logic in_valid = 1'b0;
`ifdef FOUR_BIT_COMPARATOR_CASCADE_EN
    logic casc_gt_in = 1'b0;
    logic casc_lt_in = 1'b0;
    logic casc_eq_in = 1'b1;
`endif
    logic A_gt_B, A_lt_B, A_eq_B, out_valid;

    int pass_cnt = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    four_bit_comparator dut (
        .clk       (clk),
        .rst       (rst),
        .A3        (A3),
        .A2        (A2),
        .A1        (A1),
        .A0        (A0),
        .B3        (B3),
        .B2        (B2),
        .B1        (B1),
        .B0        (B0),
        .in_valid  (in_valid),
`ifdef FOUR_BIT_COMPARATOR_CASCADE_EN
        .casc_gt_in(casc_gt_in),
        .casc_lt_in(casc_lt_in),
        .casc_eq_in(casc_eq_in),
`endif
        .A_gt_B    (A_gt_B),
        .A_lt_B    (A_lt_B),
        .A_eq_B    (A_eq_B),
        .out_valid (out_valid)
    );

    function automatic logic [3:0] observed();
        return {out_valid, A_gt_B, A_lt_B, A_eq_B};
    endfunction

    task automatic check(input string tag, input logic [3:0] exp);
        logic [3:0] obs;
        obs = observed();
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s observed={v,gt,lt,eq}=%b expected=%b", tag, obs, exp);
    endtask

    // Drive operands, then sample just after the next rising edge.
    task automatic step(input logic [3:0] a, input logic [3:0] b, input logic v);
        {A3, A2, A1, A0} = a;
        {B3, B2, B1, B0} = b;
        in_valid = v;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [3:0] a_val;
        logic [3:0] b_val;
        logic [3:0] ref_flags;

        #1;
        check("reset_initial", 4'b0000);
        @(posedge clk);
        #3;
        rst = 1'b0;

        step(4'b0000, 4'b0000, 1'b1); check("eq_0000", 4'b1001);
        step(4'b0001, 4'b0001, 1'b1); check("eq_0001", 4'b1001);
        step(4'b1111, 4'b1111, 1'b1); check("eq_1111", 4'b1001);
        step(4'b0101, 4'b0100, 1'b1); check("gt_lsb", 4'b1100);
        step(4'b1111, 4'b1110, 1'b1); check("gt_1111_1110", 4'b1100);
        step(4'b0011, 4'b1000, 1'b1); check("lt_msb", 4'b1010);
        step(4'b1011, 4'b0111, 1'b1); check("gt_msb_dom", 4'b1100);
        step(4'b0110, 4'b0111, 1'b1); check("lt_lsb", 4'b1010);

        step(4'b1010, 4'b0101, 1'b1); check("hold_load", 4'b1100);
        step(4'b0000, 4'b1111, 1'b0); check("hold_idle1", 4'b0100);
        step(4'b0011, 4'b0011, 1'b0); check("hold_idle2", 4'b0100);

        // Asynchronous reset mid-stream, between edges, with operands valid.
        {A3, A2, A1, A0} = 4'b0010;
        {B3, B2, B1, B0} = 4'b0001;
        in_valid = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        check("reset_async", 4'b0000);
        @(posedge clk);
        #1;
        check("reset_held", 4'b0000);
        #2;
        rst = 1'b0;
        step(4'b0010, 4'b0001, 1'b1); check("post_reset_gt", 4'b1100);

`ifdef FOUR_BIT_COMPARATOR_CASCADE_EN
        casc_gt_in = 1'b0; casc_lt_in = 1'b1; casc_eq_in = 1'b0;
        step(4'b0110, 4'b0110, 1'b1); check("casc_lt", 4'b1010);
        step(4'b0111, 4'b0110, 1'b1); check("casc_local_gt", 4'b1100);
        casc_gt_in = 1'b1; casc_lt_in = 1'b1; casc_eq_in = 1'b1;
        step(4'b1001, 4'b1001, 1'b1); check("casc_prio_gt", 4'b1100);
        casc_gt_in = 1'b0; casc_lt_in = 1'b0; casc_eq_in = 1'b1;
        step(4'b1001, 4'b1001, 1'b1); check("casc_eq", 4'b1001);
`endif

        for (int i = 0; i < 256; i++) begin
            a_val = i[7:4];
            b_val = i[3:0];
            ref_flags = {1'b1, a_val > b_val, a_val < b_val, a_val == b_val};
            step(a_val, b_val, 1'b1);
            check($sformatf("exh_%h_%h", a_val, b_val), ref_flags);
        end
        step(4'b0000, 4'b0000, 1'b0); check("exh_tail", 4'b0001);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
